// File: rtl/window_3x3.sv
// rtl/window_3x3.sv - 3x3 sliding window over a raster pixel stream.
// Optional macro WINDOW_3X3_ZERO_PAD_EN: emit a window per pixel with out-of-frame taps zeroed.
module window_3x3 #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int SIZE       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [SIZE-1:0]   pix_in,
  output logic              win_valid,
  output logic [9*SIZE-1:0] win,
  output logic              frame_done
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]     col_q, col_d, cur_col;
  logic [RW-1:0]     row_q, row_d, cur_row;
  logic [9*SIZE-1:0] win_q, win_d;
  logic              win_valid_q, win_valid_d;
  logic              frame_done_q, frame_done_d;

  // lb1 holds line r-1, lb2 holds line r-2; contents are never reset.
  logic [SIZE-1:0]   lb1_q [IMG_WIDTH];
  logic [SIZE-1:0]   lb2_q [IMG_WIDTH];
  logic [SIZE-1:0]   lb1_rd, lb2_rd;
  logic [SIZE-1:0]   new_col [3];
  logic              clear_old;

  // Position of the pixel being accepted this cycle; sof forces (0,0).
  always_comb begin
    cur_col = col_q;
    cur_row = row_q;
    if (pix_sof) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pix_valid) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  assign lb1_rd = lb1_q[cur_col];
  assign lb2_rd = lb2_q[cur_col];

  always_comb begin
    new_col[0] = lb2_rd;
    new_col[1] = lb1_rd;
    new_col[2] = pix_in;
    clear_old  = 1'b0;
`ifdef WINDOW_3X3_ZERO_PAD_EN
    if (cur_row < RW'(2)) new_col[0] = '0;
    if (cur_row < RW'(1)) new_col[1] = '0;
    clear_old = (cur_col == '0);
`endif
  end

  // Each tap row shifts left by one column; the newest column enters at wc=2.
  always_comb begin
    win_d = win_q;
    if (pix_valid) begin
      for (int wr = 0; wr < 3; wr++) begin
        win_d[(3*wr+0)*SIZE +: SIZE] = clear_old ? '0 : win_q[(3*wr+1)*SIZE +: SIZE];
        win_d[(3*wr+1)*SIZE +: SIZE] = clear_old ? '0 : win_q[(3*wr+2)*SIZE +: SIZE];
        win_d[(3*wr+2)*SIZE +: SIZE] = new_col[wr];
      end
    end
  end

  always_comb begin
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (pix_valid) begin
`ifdef WINDOW_3X3_ZERO_PAD_EN
      win_valid_d = 1'b1;
`else
      win_valid_d = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
`endif
      frame_done_d = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb2_q[cur_col] <= lb1_q[cur_col];
      lb1_q[cur_col] <= pix_in;
    end
  end

  assign win        = win_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_3x3.sv
// tb/tb_window_3x3.sv - directed self-checking bench for window_3x3 on a 4x4 frame.
module tb_window_3x3;
  localparam int W = 4;
  localparam int H = 4;
  localparam int S = 8;
`ifdef WINDOW_3X3_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
  localparam int EXP_WINS = W * H;
`else
  localparam bit PAD = 1'b0;
  localparam int EXP_WINS = (W - 2) * (H - 2);
`endif
  localparam logic [71:0] WIN_22  = 72'h23_22_21_13_12_11_03_02_01;
  localparam logic [71:0] WIN_00P = 72'h01_00_00_00_00_00_00_00_00;
  localparam logic [71:0] WIN_12P = 72'h13_12_11_03_02_01_00_00_00;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pix_valid;
  logic          pix_sof;
  logic [S-1:0]  pix_in;
  logic          win_valid;
  logic [9*S-1:0] win;
  logic          frame_done;

  int vectors = 0;
  int miscompares = 0;
  int nwin;
  int ndone;
  logic [71:0] win_at_22, win_at_00, win_at_12;

  window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .SIZE(S)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_in(pix_in), .win_valid(win_valid), .win(win), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) begin
      int rr, cc;
      rr = r - 2 + i / 3;
      cc = c - 2 + i % 3;
      if (rr >= 0 && cc >= 0) w[i*8 +: 8] = 8'(16 * rr + cc + 1);
    end
    return w;
  endfunction

  task automatic send(input int r, input int c, input bit sof, input bit gap);
    logic [71:0] held;
    bit ev;
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_in    = 8'(16 * r + c + 1);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    ev = PAD || (r >= 2 && c >= 2);
    chk("win_valid", {71'd0, win_valid}, {71'd0, ev});
    if (ev) begin
      nwin++;
      chk("win", win, exp_win(r, c));
    end
    if (r == 2 && c == 2) win_at_22 = win;
    if (r == 0 && c == 0) win_at_00 = win;
    if (r == 1 && c == 2) win_at_12 = win;
    chk("frame_done", {71'd0, frame_done}, {71'd0, (r == H - 1 && c == W - 1)});
    if (frame_done) ndone++;
    if (gap) begin
      held = win;
      @(posedge clk); #1;
      chk("gap_valid", {71'd0, win_valid}, 72'd0);
      chk("gap_hold", win, held);
      chk("gap_done", {71'd0, frame_done}, 72'd0);
    end
  endtask

  task automatic frame(input bit sof, input bit gap, input int npix);
    nwin  = 0;
    ndone = 0;
    for (int k = 0; k < npix; k++) send(k / W, k % W, sof && (k == 0), gap);
    if (npix == W * H) begin
      chk("win_count", 72'(nwin), 72'(EXP_WINS));
      chk("done_count", 72'(ndone), 72'd1);
      chk("first_win", win_at_22, WIN_22);
    end else begin
      chk("partial_done_count", 72'(ndone), 72'd0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {71'd0, win_valid}, 72'd0);
    chk("rst_win", win, 72'd0);
    chk("rst_done", {71'd0, frame_done}, 72'd0);
    @(negedge clk) rst_n = 1'b1;

    // Continuous frame with sof.
    frame(1'b1, 1'b0, W * H);
`ifdef WINDOW_3X3_ZERO_PAD_EN
    chk("pad_win_00", win_at_00, WIN_00P);
    chk("pad_win_12", win_at_12, WIN_12P);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("idle_valid", {71'd0, win_valid}, 72'd0);

    // Alternating valid/idle.
    frame(1'b1, 1'b1, W * H);

    // sof reasserted at (2,1): partial frame then a full restarted frame.
    frame(1'b1, 1'b0, 2 * W + 1);
    frame(1'b1, 1'b0, W * H);

    // Reset mid-frame right after (2,2) produced a valid window.
    frame(1'b1, 1'b0, 2 * W + 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {71'd0, win_valid}, 72'd0);
    chk("midrst_win", win, 72'd0);
    chk("midrst_done", {71'd0, frame_done}, 72'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    frame(1'b0, 1'b0, W * H);

    // Back-to-back frame without sof.
    frame(1'b0, 1'b0, W * H);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
